// File: rtl/reg_file_sb_pkg.sv
// rf_pkg: constants shared by decode, writeback and the register file.
//   XLEN_DEF  - default register width
//   NREGS_DEF - default number of architectural registers
//   addr_w()  - register-index width for a given register count
package rf_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  // A single-register file still needs a 1-bit index to keep ports legal.
  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the register file.
//   wen, rd_addr, wr_data      writeback port
//   rs_addr -> rs_data/rs_busy NRD packed read ports (port k at slice k)
//   issue_valid, issue_rd      decode issue; issue_waw flags a WAW hazard
//   busy_vec                   scoreboard bits
//   master: decode/writeback side; slave: register file side.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = addr_w(NREGS)
);

  logic                 wen;
  logic [AW-1:0]        rd_addr;
  logic [XLEN-1:0]      wr_data;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_data;
  logic [NRD-1:0]       rs_busy;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_waw;
  logic [NREGS-1:0]     busy_vec;

  modport master (
    output wen, rd_addr, wr_data, rs_addr, issue_valid, issue_rd,
    input  rs_data, rs_busy, issue_waw, busy_vec
  );

  modport slave (
    input  wen, rd_addr, wr_data, rs_addr, issue_valid, issue_rd,
    output rs_data, rs_busy, issue_waw, busy_vec
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: one busy bit per register for pending producers.
//   clk, rst_n            clock, async active-low reset
//   set_en_i/set_idx_i    issue of a producer for register set_idx_i
//   clr_en_i/clr_idx_i    writeback of register clr_idx_i
//   busy_vec_o            current busy bits
//   issue_waw_o           issuing onto a register that is already busy
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int ZERO_X0 = 1,
  parameter int AW      = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_idx_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_idx_i,
  output logic [NREGS-1:0] busy_vec_o,
  output logic             issue_waw_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first, then set: a simultaneous issue is a newer producer and wins.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (clr_en_i && (clr_idx_i == AW'(r))) busy_d[r] = 1'b0;
      if (set_en_i && (set_idx_i == AW'(r))) busy_d[r] = 1'b1;
    end
    if (ZERO_X0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Uses the registered bit, so a writeback in the same cycle does not hide it.
  assign issue_waw_o = set_en_i && busy_q[set_idx_i] &&
                       !((ZERO_X0 != 0) && (set_idx_i == '0));
  assign busy_vec_o  = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with pending-write scoreboard.
//   clk, rst_n  clock, async active-low reset
//   bus         reg_file_sb_if.slave: writeback, NRD combinational read ports
//               with optional write bypass, issue/WAW check, busy bits
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_X0 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int AW = addr_w(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic                wr_en;
  logic [NREGS-1:0]    busy_vec;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;

  assign wr_en = bus.wen && !((ZERO_X0 != 0) && (bus.rd_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      regs_q[bus.rd_addr] <= bus.wr_data;
    end
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_X0 (ZERO_X0),
    .AW      (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (bus.issue_valid),
    .set_idx_i   (bus.issue_rd),
    .clr_en_i    (bus.wen),
    .clr_idx_i   (bus.rd_addr),
    .busy_vec_o  (busy_vec),
    .issue_waw_o (bus.issue_waw)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic            is_x0;
    logic [XLEN-1:0] data;

    assign addr  = bus.rs_addr[k*AW +: AW];
    assign hit   = (BYPASS != 0) && bus.wen && (bus.rd_addr == addr);
    assign is_x0 = (ZERO_X0 != 0) && (addr == '0);

    // x0 check ahead of the bypass so a discarded x0 write never leaks through.
    always_comb begin
      data = regs_q[addr];
      if (is_x0)    data = '0;
      else if (hit) data = bus.wr_data;
    end

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_busy[k] = busy_vec[addr] && !hit && !is_x0;
  end

  assign bus.rs_data  = rs_data;
  assign bus.rs_busy  = rs_busy;
  assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam logic [63:0] D5 = 64'h0000_0456_7010_23D2;

  localparam int K_A_DATA = 0, K_A_BUSY = 1, K_A_VEC = 2, K_A_WAW = 3,
                 K_B_DATA = 4, K_B_BUSY = 5, K_C_DATA = 6, K_C_BUSY = 7,
                 K_C_VEC = 8, K_C_WAW = 9;

  typedef struct {
    int          kind;
    int          port;
    logic [63:0] val;
    int          step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step = 0;

  // A: defaults with bypass; B: no bypass, same stimulus; C: 3 ports, 32b, 16 regs.
  reg_file_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) if_a ();
  reg_file_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) if_b ();
  reg_file_sb_if #(.XLEN(32), .NREGS(16), .NRD(3)) if_c ();

  reg_file_sb #(.XLEN(64), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_X0(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  reg_file_sb #(.XLEN(64), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_X0(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  reg_file_sb #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(1), .ZERO_X0(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  assign if_b.wen         = if_a.wen;
  assign if_b.rd_addr     = if_a.rd_addr;
  assign if_b.wr_data     = if_a.wr_data;
  assign if_b.rs_addr     = if_a.rs_addr;
  assign if_b.issue_valid = if_a.issue_valid;
  assign if_b.issue_rd    = if_a.issue_rd;

  function automatic logic [63:0] observe(input int kind, input int port);
    case (kind)
      K_A_DATA: return if_a.rs_data[port*64 +: 64];
      K_A_BUSY: return 64'(if_a.rs_busy[port]);
      K_A_VEC:  return 64'(if_a.busy_vec);
      K_A_WAW:  return 64'(if_a.issue_waw);
      K_B_DATA: return if_b.rs_data[port*64 +: 64];
      K_B_BUSY: return 64'(if_b.rs_busy[port]);
      K_C_DATA: return 64'(if_c.rs_data[port*32 +: 32]);
      K_C_BUSY: return 64'(if_c.rs_busy[port]);
      K_C_VEC:  return 64'(if_c.busy_vec);
      K_C_WAW:  return 64'(if_c.issue_waw);
      default:  return 'x;
    endcase
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      K_A_DATA: return "a_rs_data";
      K_A_BUSY: return "a_rs_busy";
      K_A_VEC:  return "a_busy_vec";
      K_A_WAW:  return "a_issue_waw";
      K_B_DATA: return "b_rs_data";
      K_B_BUSY: return "b_rs_busy";
      K_C_DATA: return "c_rs_data";
      K_C_BUSY: return "c_rs_busy";
      K_C_VEC:  return "c_busy_vec";
      K_C_WAW:  return "c_issue_waw";
      default:  return "unknown";
    endcase
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is
  // compared on the falling edge after the stimulus that produced it.
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = observe(e.kind, e.port);
        n_cmp++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL step %0d %s[%0d]: got %h expected %h",
                   e.step, kind_name(e.kind), e.port, act, e.val);
        end
      end
    end
  end

  task automatic exp_push(input int kind, input int port, input logic [63:0] v);
    exp_t e;
    e.kind = kind; e.port = port; e.val = v; e.step = step;
    exp_q.push_back(e);
  endtask

  task automatic step_a(input logic w, input logic [4:0] rd, input logic [63:0] d,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic iv, input logic [4:0] ird);
    @(posedge clk);
    #1;
    step++;
    if_a.wen         = w;
    if_a.rd_addr     = rd;
    if_a.wr_data     = d;
    if_a.rs_addr     = {r1, r0};
    if_a.issue_valid = iv;
    if_a.issue_rd    = ird;
  endtask

  // Random-phase reference state for C.
  logic [31:0] m_reg [16];
  logic [15:0] m_busy;
  logic        c_wen, c_iv;
  logic [3:0]  c_rd, c_ird;
  logic [31:0] c_wd;
  logic [3:0]  c_ra [3];

  initial begin
    if_a.wen = 0; if_a.rd_addr = 0; if_a.wr_data = 0; if_a.rs_addr = 0;
    if_a.issue_valid = 0; if_a.issue_rd = 0;
    if_c.wen = 0; if_c.rd_addr = 0; if_c.wr_data = 0; if_c.rs_addr = 0;
    if_c.issue_valid = 0; if_c.issue_rd = 0;
    #1;
    exp_push(K_A_DATA, 0, 0); exp_push(K_A_DATA, 1, 0);
    exp_push(K_A_VEC, 0, 0);  exp_push(K_A_WAW, 0, 0);
    exp_push(K_B_DATA, 0, 0);
    step_a(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // write x5 with bypass vs none, issue x3
    step_a(1, 5, D5, 5, 0, 1, 3);
    exp_push(K_A_DATA, 0, D5); exp_push(K_B_DATA, 0, 0);
    exp_push(K_A_WAW, 0, 0);   exp_push(K_A_DATA, 1, 0);
    step_a(0, 0, 0, 5, 3, 0, 0);
    exp_push(K_A_DATA, 0, D5); exp_push(K_B_DATA, 0, D5);
    exp_push(K_A_VEC, 0, 64'(1) << 3); exp_push(K_A_BUSY, 1, 1);
    // mid-cycle reset: outputs clear without an edge
    step_a(0, 0, 0, 5, 3, 1, 3);
    rst_n = 1'b0;
    exp_push(K_A_DATA, 0, 0); exp_push(K_B_DATA, 0, 0);
    exp_push(K_A_VEC, 0, 0);  exp_push(K_A_BUSY, 1, 0);
    exp_push(K_A_WAW, 0, 0);
    step_a(1, 5, D5, 5, 0, 0, 0);
    rst_n = 1'b1;
    exp_push(K_A_DATA, 0, D5); exp_push(K_B_DATA, 0, 0);
    exp_push(K_A_VEC, 0, 0);
    // write to x0 discarded, never forwarded
    step_a(1, 0, 64'hFFFF, 5, 0, 0, 0);
    exp_push(K_A_DATA, 0, D5); exp_push(K_B_DATA, 0, D5);
    exp_push(K_A_DATA, 1, 0);  exp_push(K_B_DATA, 1, 0);
    step_a(0, 0, 0, 5, 0, 0, 0);
    exp_push(K_A_DATA, 1, 0);  exp_push(K_B_DATA, 1, 0);
    // bypass on x10
    step_a(1, 10, 1, 0, 10, 0, 0);
    exp_push(K_A_DATA, 1, 1);  exp_push(K_B_DATA, 1, 0);
    exp_push(K_A_DATA, 0, 0);
    step_a(1, 10, 2, 0, 10, 0, 0);
    exp_push(K_A_DATA, 1, 2);  exp_push(K_B_DATA, 1, 1);
    step_a(0, 0, 0, 0, 10, 0, 0);
    exp_push(K_A_DATA, 1, 2);  exp_push(K_B_DATA, 1, 2);
    // issue x7, then writeback
    step_a(0, 0, 0, 7, 10, 1, 7);
    exp_push(K_A_WAW, 0, 0); exp_push(K_A_VEC, 0, 0); exp_push(K_A_BUSY, 0, 0);
    step_a(0, 0, 0, 7, 10, 0, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7); exp_push(K_A_BUSY, 0, 1);
    exp_push(K_B_BUSY, 0, 1);
    step_a(1, 7, 64'h77, 7, 7, 0, 0);
    exp_push(K_A_BUSY, 0, 0); exp_push(K_A_BUSY, 1, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7);
    exp_push(K_A_DATA, 0, 64'h77); exp_push(K_A_DATA, 1, 64'h77);
    exp_push(K_B_BUSY, 0, 1); exp_push(K_B_DATA, 0, 0);
    step_a(0, 0, 0, 7, 10, 0, 0);
    exp_push(K_A_VEC, 0, 0); exp_push(K_A_BUSY, 0, 0);
    exp_push(K_A_DATA, 0, 64'h77);
    exp_push(K_B_BUSY, 0, 0); exp_push(K_B_DATA, 0, 64'h77);
    // issue and writeback on x7 together: set wins
    step_a(1, 7, 64'h88, 7, 10, 1, 7);
    exp_push(K_A_WAW, 0, 0); exp_push(K_A_BUSY, 0, 0);
    exp_push(K_A_DATA, 0, 64'h88);
    step_a(0, 0, 0, 7, 10, 0, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7); exp_push(K_A_BUSY, 0, 1);
    exp_push(K_A_DATA, 0, 64'h88);
    // second issue on busy x7: WAW, not masked by same-cycle writeback
    step_a(1, 7, 64'h99, 7, 10, 1, 7);
    exp_push(K_A_WAW, 0, 1); exp_push(K_A_BUSY, 0, 0);
    exp_push(K_B_BUSY, 0, 1);
    step_a(0, 0, 0, 7, 0, 1, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7); exp_push(K_A_WAW, 0, 0);
    exp_push(K_A_DATA, 0, 64'h99); exp_push(K_A_BUSY, 0, 1);
    // x0 never busy; stray write to non-busy x9
    step_a(1, 9, 5, 9, 7, 0, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7); exp_push(K_A_DATA, 0, 5);
    exp_push(K_A_BUSY, 1, 1);
    step_a(0, 0, 0, 9, 7, 0, 0);
    exp_push(K_A_VEC, 0, 64'(1) << 7); exp_push(K_A_DATA, 0, 5);
    exp_push(K_A_BUSY, 0, 0);

    // random phase on C
    for (int r = 0; r < 16; r++) m_reg[r] = 0;
    m_busy = 0;
    c_wen = 0; c_iv = 0; c_rd = 0; c_ird = 0; c_wd = 0;
    for (int k = 0; k < 3; k++) c_ra[k] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk);
      #1;
      step++;
      if (rst_n) begin
        if (c_wen && c_rd != 0) m_reg[c_rd] = c_wd;
        if (c_wen) m_busy[c_rd] = 1'b0;
        if (c_iv && c_ird != 0) m_busy[c_ird] = 1'b1;
      end
      rst_n = 1'b1;
      c_wen = 1'($urandom_range(0, 1));
      c_iv  = 1'($urandom_range(0, 1));
      c_rd  = 4'($urandom_range(0, 15));
      c_ird = 4'($urandom_range(0, 15));
      c_wd  = $urandom;
      for (int k = 0; k < 3; k++)
        c_ra[k] = ($urandom_range(0, 3) == 0) ? c_rd : 4'($urandom_range(0, 15));
      if (cyc % 8 == 3) begin
        c_ra[1] = c_ra[0];
        c_ra[2] = c_ra[0];
      end
      if (cyc == 500) begin
        rst_n = 1'b0;
        c_wen = 1'b0;
        c_iv  = 1'b0;
        for (int r = 0; r < 16; r++) m_reg[r] = 0;
        m_busy = 0;
      end
      if_c.wen = c_wen; if_c.rd_addr = c_rd; if_c.wr_data = c_wd;
      if_c.issue_valid = c_iv; if_c.issue_rd = c_ird;
      if_c.rs_addr = {c_ra[2], c_ra[1], c_ra[0]};
      for (int k = 0; k < 3; k++) begin
        logic hit;
        hit = c_wen && (c_rd == c_ra[k]);
        if (c_ra[k] == 0) exp_push(K_C_DATA, k, 0);
        else if (hit)     exp_push(K_C_DATA, k, 64'(c_wd));
        else              exp_push(K_C_DATA, k, 64'(m_reg[c_ra[k]]));
        exp_push(K_C_BUSY, k, 64'(c_ra[k] != 0 && m_busy[c_ra[k]] && !hit));
      end
      exp_push(K_C_VEC, 0, 64'(m_busy));
      exp_push(K_C_WAW, 0, 64'(c_iv && m_busy[c_ird] && c_ird != 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
